// File: rtl/sparsity_index_gen_pkg.sv
// Shared defaults and FSM encoding for the sparsity index generator.
package sparsity_index_gen_pkg;

  localparam int FLAG_W_DEF = 16;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sparsity_index_gen_ram.sv
// Single-port-write / single-port-read flag RAM with a registered read port.
// A read and a write to the same address in one cycle return the old word.
module ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage update and read-first data register.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/sparsity_index_gen.sv
// Scans stored sparsity flags and emits the offset of every nonzero element,
// with per-row (kernel mode) or whole-scan (line mode) population counts.
module sparsity_index_gen
  import sparsity_index_gen_pkg::*;
#(
  parameter int  FLAG_W = FLAG_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int IDX_W  = $clog2(FLAG_W*DEPTH),
  localparam int CNT_W  = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [FLAG_W-1:0] wr_data,
  input  logic              cfg_mode,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [3:0]        cfg_row,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IDX_W-1:0]  idx_data,
  output logic              row_cnt_valid,
  output logic [CNT_W-1:0]  row_cnt,
  output logic [CNT_W-1:0]  total_cnt
);

  localparam int BIT_W = (FLAG_W > 1) ? $clog2(FLAG_W) : 1;

  state_e              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_row_cnt_valid;
  logic [CNT_W-1:0]    r_row_cnt;
  logic [CNT_W-1:0]    r_total;
  logic [CNT_W-1:0]    r_pos;
  logic [BIT_W-1:0]    r_bit;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_len;
  logic [3:0]          r_row;
  logic                r_mode;
  logic [3:0]          r_grp_pos;
  logic [CNT_W-1:0]    r_grp_ones;

  logic [FLAG_W-1:0]   w_rd_data;
  logic                w_rd_en;
  logic                w_flag;
  logic                w_adv;
  logic                w_last;
  logic                w_grp_end;
  logic                w_word_end;
  logic [ADDR_W-1:0]   w_addr_nxt;

  ram #(
    .DATA_WIDTH (FLAG_W),
    .ADDR_WIDTH (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (w_rd_en),
    .rd_addr (r_addr),
    .rd_data (w_rd_data)
  );

  // The RAM read register doubles as the scan register: it only reloads in READ.
  assign w_rd_en    = (r_state == READ);
  assign w_flag     = w_rd_data[r_bit];
  assign w_adv      = (r_state == SCAN) && (!w_flag || idx_ready);
  assign w_last     = ((r_pos + CNT_W'(1)) == r_len);
  assign w_grp_end  = ((r_grp_pos + 4'd1) == r_row);
  assign w_word_end = (r_bit == BIT_W'(FLAG_W-1));
  assign w_addr_nxt = (r_addr == ADDR_W'(DEPTH-1)) ? '0 : r_addr + ADDR_W'(1);

  // Control FSM, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_row_cnt_valid <= 1'b0;
      r_row_cnt       <= '0;
      r_total         <= '0;
      r_pos           <= '0;
      r_bit           <= '0;
      r_addr          <= '0;
      r_len           <= '0;
      r_row           <= 4'd0;
      r_mode          <= 1'b0;
      r_grp_pos       <= 4'd0;
      r_grp_ones      <= '0;
    end else begin
      r_done          <= 1'b0;
      r_row_cnt_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode     <= cfg_mode;
            r_addr     <= cfg_base;
            r_len      <= cfg_len;
            r_row      <= cfg_row;
            r_total    <= '0;
            r_pos      <= '0;
            r_bit      <= '0;
            r_grp_pos  <= 4'd0;
            r_grp_ones <= '0;
            r_busy     <= 1'b1;
            if (cfg_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              if (!cfg_mode) begin
                r_row_cnt_valid <= 1'b1;
                r_row_cnt       <= '0;
              end
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          r_state <= SCAN;
        end
        SCAN: begin
          if (w_adv) begin
            r_pos   <= r_pos + CNT_W'(1);
            r_total <= r_total + CNT_W'(w_flag);
            if (r_mode && (w_grp_end || w_last)) begin
              r_row_cnt_valid <= 1'b1;
              r_row_cnt       <= r_grp_ones + CNT_W'(w_flag);
            end
            if (w_grp_end) begin
              r_grp_pos  <= 4'd0;
              r_grp_ones <= '0;
            end else begin
              r_grp_pos  <= r_grp_pos + 4'd1;
              r_grp_ones <= r_grp_ones + CNT_W'(w_flag);
            end
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              if (!r_mode) begin
                r_row_cnt_valid <= 1'b1;
                r_row_cnt       <= r_total + CNT_W'(w_flag);
              end
            end else if (w_word_end) begin
              r_bit   <= '0;
              r_addr  <= w_addr_nxt;
              r_state <= READ;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign idx_valid     = (r_state == SCAN) && w_flag;
  assign idx_data      = r_pos[IDX_W-1:0];
  assign row_cnt_valid = r_row_cnt_valid;
  assign row_cnt       = r_row_cnt;
  assign total_cnt     = r_total;

endmodule

// File: tb/tb_sparsity_index_gen.sv
// Directed bench for sparsity_index_gen: a flag-list model predicts indices,
// row counts, totals and done timing; a negedge monitor compares every cycle.
module tb_sparsity_index_gen;

  localparam int FW = 16;
  localparam int DP = 64;
  localparam int AW = 6;
  localparam int IW = 10;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_data;
  logic          cfg_mode;
  logic [AW-1:0] cfg_base;
  logic [CW-1:0] cfg_len;
  logic [3:0]    cfg_row;
  logic          start;
  logic          busy;
  logic          done;
  logic          idx_valid;
  logic          idx_ready;
  logic [IW-1:0] idx_data;
  logic          row_cnt_valid;
  logic [CW-1:0] row_cnt;
  logic [CW-1:0] total_cnt;

  sparsity_index_gen #(.FLAG_W(FW), .DEPTH(DP)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cfg_mode      (cfg_mode),
    .cfg_base      (cfg_base),
    .cfg_len       (cfg_len),
    .cfg_row       (cfg_row),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .idx_valid     (idx_valid),
    .idx_ready     (idx_ready),
    .idx_data      (idx_data),
    .row_cnt_valid (row_cnt_valid),
    .row_cnt       (row_cnt),
    .total_cnt     (total_cnt)
  );

  always #5 clk = ~clk;

  int            n_total = 0;
  int            n_bad   = 0;
  int            cyc     = 0;
  logic [FW-1:0] mem_m [DP];
  int            exp_idx[$];
  int            exp_row[$];
  int            obs_idx[$];
  int            obs_row[$];
  int            obs_cyc[$];
  int            exp_total;
  int            exp_done_rel;
  int            obs_done_rel;
  int            start_cyc;
  bit            seen_done;
  bit            mon_en = 1'b0;
  bit            prev_valid;
  bit            prev_ready;
  int            prev_data;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [FW-1:0] d);
    wr_req  = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    mem_m[a] = d;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_idx_valid"}, int'(idx_valid), 0);
    chk({tag, "_idx_data"}, int'(idx_data), 0);
    chk({tag, "_row_valid"}, int'(row_cnt_valid), 0);
    chk({tag, "_row_cnt"}, int'(row_cnt), 0);
    chk({tag, "_total"}, int'(total_cnt), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: every accepted index, row count and done pulse against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_valid = 1'b0;
      end else begin
        if (start && !busy) start_cyc = cyc;
        if (idx_valid) begin
          if (prev_valid && !prev_ready) chk("idx_stable", int'(idx_data), prev_data);
          if (idx_ready) begin
            obs_idx.push_back(int'(idx_data));
            obs_cyc.push_back(cyc);
            if (exp_idx.size() == 0) begin
              n_total++; n_bad++;
              $display("FAIL idx_extra: got %0d expected none", idx_data);
            end else begin
              chk("idx_data", int'(idx_data), exp_idx.pop_front());
            end
          end
        end
        if (row_cnt_valid) begin
          obs_row.push_back(int'(row_cnt));
          if (exp_row.size() == 0) begin
            n_total++; n_bad++;
            $display("FAIL row_extra: got %0d expected none", row_cnt);
          end else begin
            chk("row_cnt", int'(row_cnt), exp_row.pop_front());
          end
        end
        if (done) begin
          obs_done_rel = cyc - start_cyc;
          seen_done = 1'b1;
          chk("done_cycle", obs_done_rel, exp_done_rel);
          chk("total_at_done", int'(total_cnt), exp_total);
          chk("busy_in_done", int'(busy), 1);
        end
        prev_valid = idx_valid;
        prev_ready = idx_ready;
        prev_data  = int'(idx_data);
      end
    end
  end

  // Builds the expected flag list from the memory image, then drives one scan.
  task automatic run_scan(input bit mode, input int base, input int len, input int row,
                          input int stalls, input bit rf, input logic [FW-1:0] rf_data);
    int ones = 0;
    int g = 0;
    int stall_left = stalls;
    logic [FW-1:0] w;
    exp_idx.delete(); exp_row.delete();
    obs_idx.delete(); obs_row.delete(); obs_cyc.delete();
    for (int k = 0; k < len; k++) begin
      w = mem_m[(base + k / FW) % DP];
      if (w[k % FW]) begin
        exp_idx.push_back(k);
        ones++;
        g++;
      end
      if (mode && ((((k + 1) % row) == 0) || (k == len - 1))) begin
        exp_row.push_back(g);
        g = 0;
      end
    end
    if (!mode) exp_row.push_back(ones);
    exp_total    = ones;
    exp_done_rel = (len == 0) ? 1 : (len + FW - 1) / FW + len + stalls + 1;
    if (rf) mem_m[base] = rf_data;
    cfg_mode  = mode;
    cfg_base  = AW'(base);
    cfg_len   = CW'(len);
    cfg_row   = 4'(row);
    idx_ready = 1'b1;
    seen_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (rf) begin
      wr_req  = 1'b1;
      wr_addr = AW'(base);
      wr_data = rf_data;
    end
    for (int c = 0; c < 300 && !seen_done; c++) begin
      tick();
      wr_req = 1'b0;
      if (stall_left > 0 && idx_valid) begin
        idx_ready = 1'b0;
        stall_left--;
      end else begin
        idx_ready = 1'b1;
      end
    end
    if (!seen_done) begin
      n_total++; n_bad++;
      $display("FAIL done_timeout: got no done expected done");
    end
    chk("busy_after_done", int'(busy), 0);
    chk("total_hold", int'(total_cnt), exp_total);
    chk("idx_left", exp_idx.size(), 0);
    chk("row_left", exp_row.size(), 0);
    tick();
  endtask

  task automatic pin_list(input string nm, input int q[$], input int a0, input int a1,
                          input int a2, input int n);
    int lit[3];
    lit[0] = a0; lit[1] = a1; lit[2] = a2;
    chk({nm, "_n"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) chk(nm, q[i], lit[i]);
  endtask

  task automatic pin_kernel(input string tag);
    int lit[6];
    lit = '{0, 2, 4, 5, 7, 8};
    chk({tag, "_idx_n"}, obs_idx.size(), 6);
    for (int i = 0; i < 6 && i < obs_idx.size(); i++) chk({tag, "_idx"}, obs_idx[i], lit[i]);
    pin_list({tag, "_row"}, obs_row, 2, 2, 2, 3);
    chk({tag, "_total"}, int'(total_cnt), 6);
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_mode = 1'b0; cfg_base = '0; cfg_len = '0; cfg_row = 4'd1;
    start = 1'b0; idx_ready = 1'b1;
    repeat (3) tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();
    for (int a = 0; a < DP; a++) wr(a, 16'h0000);
    wr(0, 16'h01B5); wr(3, 16'h8000); wr(4, 16'h0001); wr(10, 16'h0004);
    mon_en = 1'b1;

    run_scan(1'b1, 0, 9, 3, 0, 1'b0, 16'h0000);
    pin_kernel("kernel");

    run_scan(1'b0, 3, 32, 1, 0, 1'b0, 16'h0000);
    pin_list("boundary_idx", obs_idx, 15, 16, 0, 2);
    pin_list("boundary_row", obs_row, 2, 0, 0, 1);
    if (obs_cyc.size() == 2) chk("boundary_bubble", obs_cyc[1] - obs_cyc[0], 2);

    run_scan(1'b0, 20, 16, 1, 0, 1'b0, 16'h0000);
    chk("zero_idx_n", obs_idx.size(), 0);
    chk("zero_done_rel", obs_done_rel, 18);

    wr(63, 16'h0001); wr(0, 16'h0001);
    run_scan(1'b0, 63, 32, 1, 5, 1'b0, 16'h0000);
    pin_list("wrap_idx", obs_idx, 0, 16, 0, 2);
    chk("wrap_done_rel", obs_done_rel, 40);

    run_scan(1'b0, 5, 0, 1, 0, 1'b0, 16'h0000);
    chk("len0_done_rel", obs_done_rel, 1);
    pin_list("len0_row", obs_row, 0, 0, 0, 1);

    run_scan(1'b0, 10, 4, 1, 0, 1'b1, 16'h0008);
    pin_list("readfirst_old", obs_idx, 2, 0, 0, 1);
    run_scan(1'b0, 10, 4, 1, 0, 1'b0, 16'h0000);
    pin_list("readfirst_new", obs_idx, 3, 0, 0, 1);

    wr(0, 16'h01B5);
    mon_en = 1'b0;
    cfg_mode = 1'b1; cfg_base = '0; cfg_len = CW'(9); cfg_row = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("midreset");
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    run_scan(1'b1, 0, 9, 3, 0, 1'b0, 16'h0000);
    pin_kernel("restart");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sparsity_index_gen.md
SPARSITY_INDEX_GEN -- requirements
Module: sparsity_index_gen

Interface
REQ-001 SHALL have parameter FLAG_W, default 16: sparsity flags per RAM word, 1 = nonzero element.
REQ-002 SHALL have parameter DEPTH, default 64: RAM words; ADDR_W = clog2(DEPTH), IDX_W = clog2(FLAG_W*DEPTH), CNT_W = IDX_W+1.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port wr_req, input, 1: write strobe.
REQ-006 SHALL have ports wr_addr, input, ADDR_W, and wr_data, input, FLAG_W: write address and flag word; bit i = element i.
REQ-007 SHALL have port cfg_mode, input, 1: 0 = line mode, 1 = kernel mode.
REQ-008 SHALL have ports cfg_base, input, ADDR_W; cfg_len, input, CNT_W (flags to scan, 0..FLAG_W*DEPTH); cfg_row, input, 4 (kernel row length, 1..15).
REQ-009 SHALL have ports start, input, 1; busy, output, 1; done, output, 1 (one-cycle pulse).
REQ-010 SHALL have ports idx_valid, output, 1; idx_ready, input, 1; idx_data, output, IDX_W (offset of a nonzero flag from element 0 of cfg_base).
REQ-011 SHALL have ports row_cnt_valid, output, 1; row_cnt, output, CNT_W; total_cnt, output, CNT_W.

Function
REQ-012 SHALL contain an FSM with states IDLE, READ, SCAN, DONE.
REQ-013 In IDLE, start SHALL latch cfg_* and go to READ; start is ignored outside IDLE.
REQ-014 READ SHALL issue one RAM read; the word SHALL be loaded into a scan register next cycle and SCAN entered. Read latency is 1.
REQ-015 SCAN SHALL evaluate one flag per cycle, LSB first; a 0 flag SHALL advance immediately.
REQ-016 A 1 flag SHALL assert idx_valid with idx_data = offset; the flag SHALL advance only on idx_valid && idx_ready; idx_data SHALL stay stable while stalled.
REQ-017 After bit FLAG_W-1 with flags remaining, the FSM SHALL return to READ at address+1 mod DEPTH. This costs one bubble cycle per word.
REQ-018 After flag cfg_len-1 is consumed, the FSM SHALL enter DONE, pulse done for one cycle, and return to IDLE.
REQ-019 With cfg_len = 0, no RAM read SHALL occur; the FSM goes IDLE -> DONE -> IDLE with total_cnt = 0.
REQ-020 Kernel mode SHALL pulse row_cnt_valid after each group of cfg_row flags, with row_cnt = ones in that group; a trailing partial group SHALL also be reported.
REQ-021 Line mode SHALL pulse row_cnt_valid once, in the DONE cycle, with row_cnt = total.
REQ-022 row_cnt_valid SHALL NOT be back-pressured.
REQ-023 total_cnt SHALL count ones in the scan, clear on accepted start, and hold after done.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 A write and a read to the same address in the same cycle SHALL return the old data (read-first); writes are allowed in all states.

Reset
REQ-026 Reset SHALL force IDLE and set busy, done, idx_valid, idx_data, row_cnt_valid, row_cnt and total_cnt to 0, including mid-scan; RAM contents are not cleared.

Structure
REQ-027 Parameter defaults and FSM state encoding SHALL live in the shared package; derived widths are computed locally.
REQ-028 Flag storage SHALL be the existing ram sub-module (DATA_WIDTH=FLAG_W, ADDR_WIDTH=ADDR_W), instantiated once.

Verification (FLAG_W=16, DEPTH=64)
REQ-029 Kernel scan: word0=0x01B5, mode=1, row=3, len=9, base=0, ready=1 -> idx 0,2,4,5,7,8; row_cnt 2,2,2; total 6.
REQ-030 Word boundary: word3=0x8000, word4=0x0001, mode=0, base=3, len=32 -> idx 15,16 with one bubble between words; single row_cnt=2; total 2.
REQ-031 All-zero word: len=16, start in cycle 0 -> no idx_valid, SCAN cycles 2..17, done in cycle 18.
REQ-032 Backpressure and wrap: base=63, len=32, word63=0x0001, word0=0x0001, ready low 5 cycles on the first idx -> idx_data=0 held stable, then idx 16; reads hit words 63 then 0.
REQ-033 Reset in the middle of SCAN, then start again -> all outputs 0 immediately; the restarted scan gives the same results as a clean run.
